addr_reg_bank: RTL and testbench

//  Parametrised bank of NREG address registers. Replaces the single 12-bit AR.

---
 rtl/addr_reg_bank.sv | 101 ++++++++++
 tb/tb_addr_reg_bank.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/addr_reg_bank.sv
// Bank of NREG address registers with wrap/saturate stepping, sticky overflow
// flags and a one-deep shadow per entry; the SEL entry drives the address bus.
module addr_reg_bank #(
  parameter int AW   = 12,
  parameter int NREG = 4,
  parameter int STEP = 1,
  localparam int SW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          RST_N,
  input  logic          CLR_GLOBAL,
  input  logic [SW-1:0] SEL,
  input  logic [AW-1:0] in_AR,
  input  logic          LD,
  input  logic          INR,
  input  logic          DEC,
  input  logic          CLR,
  input  logic          SAVE,
  input  logic          RESTORE,
  input  logic          SAT,
  output logic [AW-1:0] out_AR,
  output logic          out_OVF,
  output logic          out_ZERO,
  output logic          out_MAX
);

  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  logic [AW-1:0] regs   [NREG];
  logic [AW-1:0] shadow [NREG];
  logic [NREG-1:0] ovf;

  logic          sel_valid;
  logic [AW-1:0] cur_val;
  logic [AW-1:0] cur_shadow;
  logic          cur_ovf;
  logic [AW:0]   inc_full;
  logic [AW:0]   dec_full;
  logic          wr_en;
  logic [AW-1:0] nxt_val;
  logic          nxt_ovf;

  // Out-of-range SEL (non-power-of-2 NREG) reads as an empty entry.
  assign sel_valid  = (int'(SEL) < NREG);
  assign cur_val    = sel_valid ? regs[SEL]   : '0;
  assign cur_shadow = sel_valid ? shadow[SEL] : '0;
  assign cur_ovf    = sel_valid ? ovf[SEL]    : 1'b0;

  // Bit AW carries the carry (increment) or borrow (decrement).
  assign inc_full = {1'b0, cur_val} + STEP_W;
  assign dec_full = {1'b0, cur_val} - STEP_W;

  always_comb begin
    wr_en   = 1'b0;
    nxt_val = cur_val;
    nxt_ovf = cur_ovf;
    if (CLR) begin
      wr_en   = 1'b1;
      nxt_val = '0;
      nxt_ovf = 1'b0;
    end else if (RESTORE) begin
      wr_en   = 1'b1;
      nxt_val = cur_shadow;
    end else if (LD) begin
      wr_en   = 1'b1;
      nxt_val = in_AR;
      nxt_ovf = 1'b0;
    end else if (INR && !DEC) begin
      wr_en   = 1'b1;
      nxt_val = (inc_full[AW] && SAT) ? '1 : inc_full[AW-1:0];
      nxt_ovf = cur_ovf | inc_full[AW];
    end else if (DEC && !INR) begin
      wr_en   = 1'b1;
      nxt_val = (dec_full[AW] && SAT) ? '0 : dec_full[AW-1:0];
      nxt_ovf = cur_ovf | dec_full[AW];
    end
  end

  // SAVE runs alongside the priority chain and captures the pre-edge value.
  always_ff @(posedge clk) begin
    if (!RST_N || CLR_GLOBAL) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      ovf <= '0;
    end else if (sel_valid) begin
      if (wr_en) begin
        regs[SEL] <= nxt_val;
        ovf[SEL]  <= nxt_ovf;
      end
      if (SAVE) shadow[SEL] <= cur_val;
    end
  end

  assign out_AR   = cur_val;
  assign out_OVF  = cur_ovf;
  assign out_ZERO = (cur_val == '0);
  assign out_MAX  = (cur_val == '1);

endmodule

// File: tb/tb_addr_reg_bank.sv
// Directed scoreboard bench for addr_reg_bank: expected {AR,OVF,ZERO,MAX}
// words are queued per step and popped when the DUT output is sampled.
module tb_addr_reg_bank;

  logic        clk = 1'b0;
  logic        RST_N, CLR_GLOBAL;
  logic [1:0]  SEL;
  logic [11:0] in_AR;
  logic        LD, INR, DEC, CLR, SAVE, RESTORE, SAT;
  logic [11:0] out_AR;
  logic        out_OVF, out_ZERO, out_MAX;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;

  addr_reg_bank #(.AW(12), .NREG(4), .STEP(1)) dut (
    .clk(clk), .RST_N(RST_N), .CLR_GLOBAL(CLR_GLOBAL), .SEL(SEL),
    .in_AR(in_AR), .LD(LD), .INR(INR), .DEC(DEC), .CLR(CLR), .SAVE(SAVE),
    .RESTORE(RESTORE), .SAT(SAT), .out_AR(out_AR), .out_OVF(out_OVF),
    .out_ZERO(out_ZERO), .out_MAX(out_MAX)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(string tag, logic [11:0] ar, logic ovf);
    exp_t e;
    e.tag = tag;
    e.val = {ar, ovf, (ar == 12'h000), (ar == 12'hFFF)};
    return e;
  endfunction

  task automatic drive(logic [1:0] s, logic ld, logic inr, logic dec, logic clr,
                       logic save, logic restore, logic sat, logic [11:0] din);
    SEL = s; LD = ld; INR = inr; DEC = dec; CLR = clr;
    SAVE = save; RESTORE = restore; SAT = sat; in_AR = din;
  endtask

  // Clock the driven strobes in, queue the expected post-edge result, drop strobes.
  task automatic applyStimulus(string tag, logic [11:0] ar, logic ovf);
    sb.push_back(mk(tag, ar, ovf));
    @(posedge clk);
    #1;
    LD = 0; INR = 0; DEC = 0; CLR = 0; SAVE = 0; RESTORE = 0; CLR_GLOBAL = 0;
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [14:0] obs;
    if (sb.size() == 0) begin
      fail_cnt++;
      $display("[TB] FAIL scoreboard: observed=empty required=entry");
      return;
    end
    e   = sb.pop_front();
    #1;
    obs = {out_AR, out_OVF, out_ZERO, out_MAX};
    cmp_cnt++;
    assert (obs === e.val) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: AR/OVF/ZERO/MAX observed=%h/%b%b%b required=%h/%b%b%b",
             e.tag, obs[14:3], obs[2], obs[1], obs[0],
             e.val[14:3], e.val[2], e.val[1], e.val[0]);
    end
  endtask

  task automatic readBack(string tag, logic [1:0] s, logic [11:0] ar, logic ovf);
    SEL = s;
    sb.push_back(mk(tag, ar, ovf));
    checkOutput();
  endtask

  task automatic step(string tag, logic [11:0] ar, logic ovf);
    applyStimulus(tag, ar, ovf);
    checkOutput();
  endtask

  initial begin
    // Reset held two cycles with LD active; reset must win.
    CLR_GLOBAL = 0; RST_N = 0;
    drive(2'd0, 1, 0, 0, 0, 0, 0, 0, 12'h5A5);
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 4; i++) readBack($sformatf("rst_e%0d", i), 2'(i), 12'h000, 0);
    RST_N = 1; LD = 0;

    drive(2'd1, 1, 0, 0, 0, 0, 0, 0, 12'hFFE); step("ld_ffe", 12'hFFE, 0);
    drive(2'd1, 0, 1, 0, 0, 0, 0, 0, 12'h000); step("inr_fff", 12'hFFF, 0);
    drive(2'd1, 0, 1, 0, 0, 0, 0, 0, 12'h000); step("inr_wrap", 12'h000, 1);
    drive(2'd1, 0, 1, 0, 0, 0, 0, 0, 12'h000); step("inr_001", 12'h001, 1);
    readBack("sel0_idle", 2'd0, 12'h000, 0);
    drive(2'd1, 1, 0, 0, 0, 0, 0, 1, 12'hFFF); step("ld_fff", 12'hFFF, 0);
    drive(2'd1, 0, 1, 0, 0, 0, 0, 1, 12'h000); step("inr_sat", 12'hFFF, 1);

    drive(2'd2, 1, 0, 0, 0, 0, 0, 1, 12'h001); step("ld_001", 12'h001, 0);
    drive(2'd2, 0, 0, 1, 0, 0, 0, 1, 12'h000); step("dec_000", 12'h000, 0);
    drive(2'd2, 0, 0, 1, 0, 0, 0, 1, 12'h000); step("dec_sat", 12'h000, 1);
    drive(2'd2, 1, 0, 0, 0, 0, 0, 0, 12'h010); step("ld_clr_ovf", 12'h010, 0);
    drive(2'd2, 1, 0, 0, 0, 0, 0, 0, 12'h000); step("ld_000", 12'h000, 0);
    drive(2'd2, 0, 0, 1, 0, 0, 0, 0, 12'h000); step("dec_wrap", 12'hFFF, 1);
    drive(2'd2, 1, 0, 0, 1, 0, 0, 0, 12'h555); step("clr_over_ld", 12'h000, 0);

    drive(2'd3, 1, 0, 0, 0, 1, 0, 0, 12'h123); step("ld_save", 12'h123, 0);
    drive(2'd3, 0, 1, 0, 0, 1, 0, 0, 12'h000); step("inr_save", 12'h124, 0);
    drive(2'd3, 0, 0, 0, 0, 0, 1, 0, 12'h000); step("restore_pre", 12'h123, 0);
    drive(2'd3, 0, 1, 0, 0, 0, 0, 0, 12'h000); step("inr_124", 12'h124, 0);
    drive(2'd3, 0, 0, 0, 0, 1, 0, 0, 12'h000); step("save_124", 12'h124, 0);
    drive(2'd3, 1, 0, 0, 0, 0, 0, 0, 12'h000); step("ld_zero", 12'h000, 0);
    drive(2'd3, 1, 0, 0, 0, 0, 1, 0, 12'h777); step("restore_124", 12'h124, 0);

    drive(2'd0, 1, 1, 0, 0, 0, 0, 0, 12'h040); step("ld_over_inr", 12'h040, 0);
    drive(2'd0, 0, 1, 1, 0, 0, 0, 0, 12'h000); step("inr_dec_hold", 12'h040, 0);
    readBack("sel1_isolated", 2'd1, 12'hFFF, 1);

    drive(2'd2, 1, 0, 0, 0, 0, 0, 0, 12'h0AA); step("ld_0aa", 12'h0AA, 0);
    drive(2'd3, 0, 0, 0, 0, 1, 0, 0, 12'h000); step("save_pre_g", 12'h124, 0);
    CLR_GLOBAL = 1;
    drive(2'd3, 1, 1, 0, 0, 1, 0, 0, 12'hFFF); step("clr_global", 12'h000, 0);
    for (int i = 0; i < 4; i++) readBack($sformatf("glob_e%0d", i), 2'(i), 12'h000, 0);
    drive(2'd3, 0, 0, 0, 0, 0, 1, 0, 12'h000); step("restore_cleared", 12'h000, 0);

    if (sb.size() != 0) begin
      fail_cnt++;
      $display("[TB] FAIL scoreboard_drain: observed=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
